dma_block_engine: RTL and testbench

//   Device-side DMA engine for the cached TSC CPU. It accepts a transfer command, requests
//   the shared memory bus, and once granted writes the device buffer to memory one

---
 rtl/dma_block_engine.sv | 158 +++++++++++++++
 tb/tb_dma_block_engine.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_block_engine.sv
// -----------------------------------------------------------------------------
// dma_block_engine
//   Device-side DMA engine. It takes a transfer command, requests the shared
//   memory bus and, once granted, writes the device buffer to memory one
//   block (BLOCK_WORDS words) at a time. Each block holds mem_writeM for
//   MEM_LATENCY cycles. After the last block the bus is released and dma_end
//   pulses for one cycle.
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous, active-high reset
//   cmd_valid      start request
//   cmd_ready      engine idle; a command is accepted on cmd_valid & cmd_ready
//   cmd_addr       first memory word address
//   cmd_len        transfer length in words
//   dev_block_idx  index of the device block currently being written
//   dev_data       device buffer block at dev_block_idx (combinational input)
//   BUS_Request    bus request to the CPU-side controller
//   BUS_Grant      bus grant from the CPU-side controller
//   mem_writeM     memory write strobe
//   mem_address    memory block address
//   mem_data       write data; dev_data while mem_writeM is high, else 0
//   busy           transfer in progress (not idle)
//   dma_end        one-cycle completion pulse
// -----------------------------------------------------------------------------
module dma_block_engine #(
  parameter int WORD_SIZE   = 16,
  parameter int BLOCK_WORDS = 4,
  parameter int MEM_LATENCY = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               cmd_valid,
  output logic                               cmd_ready,
  input  logic [WORD_SIZE-1:0]               cmd_addr,
  input  logic [7:0]                         cmd_len,
  output logic [7:0]                         dev_block_idx,
  input  logic [WORD_SIZE*BLOCK_WORDS-1:0]   dev_data,
  output logic                               BUS_Request,
  input  logic                               BUS_Grant,
  output logic                               mem_writeM,
  output logic [WORD_SIZE-1:0]               mem_address,
  output logic [WORD_SIZE*BLOCK_WORDS-1:0]   mem_data,
  output logic                               busy,
  output logic                               dma_end
);

  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WRITE,
    S_DONE
  } state_t;

  state_t               r_state, w_state_next;
  logic [WORD_SIZE-1:0] r_cur_addr, w_cur_addr_next;
  logic [8:0]           r_nblocks, w_nblocks_next;
  logic [8:0]           r_blk, w_blk_next;
  logic [CNT_W-1:0]     r_cnt, w_cnt_next;

  logic [8:0]           w_nblocks_cmd;
  logic                 w_last_cnt;
  logic                 w_last_blk;

  // Block count rounded up; 9 bits so 255 + (BLOCK_WORDS-1) cannot overflow.
  assign w_nblocks_cmd = ({1'b0, cmd_len} + 9'(BLOCK_WORDS - 1)) / 9'(BLOCK_WORDS);
  assign w_last_cnt    = (r_cnt == CNT_W'(MEM_LATENCY - 1));
  assign w_last_blk    = (r_blk == (r_nblocks - 9'd1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cur_addr <= '0;
      r_nblocks  <= '0;
      r_blk      <= '0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state_next;
      r_cur_addr <= w_cur_addr_next;
      r_nblocks  <= w_nblocks_next;
      r_blk      <= w_blk_next;
      r_cnt      <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_cur_addr_next = r_cur_addr;
    w_nblocks_next  = r_nblocks;
    w_blk_next      = r_blk;
    w_cnt_next      = r_cnt;

    cmd_ready       = 1'b0;
    busy            = 1'b1;
    BUS_Request     = 1'b0;
    mem_writeM      = 1'b0;
    mem_address     = '0;
    dev_block_idx   = '0;
    dma_end         = 1'b0;

    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          w_cur_addr_next = cmd_addr;
          w_nblocks_next  = w_nblocks_cmd;
          w_blk_next      = '0;
          w_cnt_next      = '0;
          // A zero-length command never touches the bus.
          w_state_next    = (w_nblocks_cmd == 9'd0) ? S_DONE : S_REQ;
        end
      end

      S_REQ: begin
        BUS_Request = 1'b1;
        if (BUS_Grant) begin
          w_state_next = S_WRITE;
        end
      end

      S_WRITE: begin
        BUS_Request   = 1'b1;
        mem_writeM    = 1'b1;
        mem_address   = r_cur_addr;
        dev_block_idx = r_blk[7:0];
        if (!BUS_Grant) begin
          // Losing the grant wins over completion: the whole block is redone.
          w_cnt_next   = '0;
          w_state_next = S_REQ;
        end else if (w_last_cnt) begin
          w_cnt_next      = '0;
          w_blk_next      = r_blk + 9'd1;
          w_cur_addr_next = r_cur_addr + WORD_SIZE'(BLOCK_WORDS);
          if (w_last_blk) begin
            w_state_next = S_DONE;
          end
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end

      S_DONE: begin
        dma_end      = 1'b1;
        w_state_next = S_IDLE;
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign mem_data = mem_writeM ? dev_data : '0;

endmodule

// File: tb/tb_dma_block_engine.sv
// -----------------------------------------------------------------------------
// tb_dma_block_engine
//   Directed bench for dma_block_engine. Stimulus pushes expected block writes
//   and completion events into queues; a monitor pops them when the DUT
//   completes a block (MEM_LATENCY consecutive write cycles at one address)
//   or pulses dma_end. A small arbiter process answers BUS_Request with a
//   configurable grant delay and an optional grant drop.
// -----------------------------------------------------------------------------
module tb_dma_block_engine;

  localparam int ML = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_addr = 16'h0;
  logic [7:0]  cmd_len = 8'h0;
  logic [7:0]  dev_block_idx;
  logic [63:0] dev_data;
  logic        BUS_Request;
  logic        BUS_Grant = 1'b0;
  logic        mem_writeM;
  logic [15:0] mem_address;
  logic [63:0] mem_data;
  logic        busy;
  logic        dma_end;

  dma_block_engine #(
    .WORD_SIZE   (16),
    .BLOCK_WORDS (4),
    .MEM_LATENCY (ML)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_addr      (cmd_addr),
    .cmd_len       (cmd_len),
    .dev_block_idx (dev_block_idx),
    .dev_data      (dev_data),
    .BUS_Request   (BUS_Request),
    .BUS_Grant     (BUS_Grant),
    .mem_writeM    (mem_writeM),
    .mem_address   (mem_address),
    .mem_data      (mem_data),
    .busy          (busy),
    .dma_end       (dma_end)
  );

  always #5 clk = ~clk;

  // Number of rising edges so far; read at negedges.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // Device buffer model: each block has a distinct pattern derived from its index.
  function automatic logic [63:0] pattern(input logic [7:0] idx);
    return {8'hD0, idx, 8'h3C, ~idx, 8'h81, idx ^ 8'h5A, 8'hE7, idx + 8'h11};
  endfunction

  assign dev_data = pattern(dev_block_idx);

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  idx;
  } blk_t;

  typedef struct {
    int end_cyc;
    int nblk;
  } end_t;

  blk_t exp_blk[$];
  end_t exp_end[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Arbiter (bus responder)
  // ---------------------------------------------------------------------------
  int          grant_delay = 0;
  bit          drop_arm = 1'b0;
  int          drop_left = 0;
  int          arb_req_cnt = 0;
  int          arb_run = 0;
  logic        arb_prev_wm = 1'b0;
  logic [15:0] arb_prev_addr = 16'h0;

  initial begin
    forever begin
      @(negedge clk);
      if (mem_writeM && arb_prev_wm && mem_address == arb_prev_addr) arb_run++;
      else arb_run = mem_writeM ? 1 : 0;
      arb_prev_wm   = mem_writeM;
      arb_prev_addr = mem_address;
      // Drop the grant during the cnt==2 cycle of block 1.
      if (drop_arm && mem_writeM && dev_block_idx == 8'd1 && arb_run == 3) begin
        drop_left = 3;
        drop_arm  = 1'b0;
      end
      if (BUS_Request) begin
        BUS_Grant = (arb_req_cnt >= grant_delay) && (drop_left == 0);
        arb_req_cnt++;
      end else begin
        BUS_Grant   = 1'b0;
        arb_req_cnt = 0;
      end
      if (drop_left > 0) drop_left--;
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  int          mon_run = 0;
  logic        mon_wm = 1'b0;
  logic [15:0] mon_addr = 16'h0;
  int          mon_blocks = 0;
  blk_t        mon_b;
  end_t        mon_e;

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        mon_run    = 0;
        mon_wm     = 1'b0;
        mon_blocks = 0;
      end else begin
        if (!mem_writeM) check("mem_data_idle_zero", mem_data, 64'h0);
        if (mem_writeM && mon_wm && mem_address == mon_addr) mon_run++;
        else mon_run = mem_writeM ? 1 : 0;
        mon_wm   = mem_writeM;
        mon_addr = mem_address;
        if (mon_run == ML) begin
          mon_run = 0;
          mon_blocks++;
          checks++;
          if (exp_blk.size() == 0) begin
            failures++;
            $display("FAIL unexpected_block: got addr %h idx %0d expected none", mem_address, dev_block_idx);
          end else begin
            mon_b = exp_blk.pop_front();
            check("blk_addr", 64'(mem_address), 64'(mon_b.addr));
            check("blk_idx", 64'(dev_block_idx), 64'(mon_b.idx));
            check("blk_data", mem_data, pattern(mon_b.idx));
          end
        end
        if (dma_end) begin
          checks++;
          if (exp_end.size() == 0) begin
            failures++;
            $display("FAIL unexpected_dma_end: got pulse at cycle %0d expected none", cyc);
          end else begin
            mon_e = exp_end.pop_front();
            check("end_cycle", 64'(cyc), 64'(mon_e.end_cyc));
            check("end_blocks", 64'(mon_blocks), 64'(mon_e.nblk));
            check("done_bus_req_low", 64'(BUS_Request), 64'(0));
            check("done_writeM_low", 64'(mem_writeM), 64'(0));
          end
          mon_blocks = 0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  // lat = edges from the accept edge to the edge after which dma_end is high.
  task automatic issue(input logic [15:0] addr, input logic [7:0] len, input int nb,
                       input int lat, input bit expect_it);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_addr  = addr;
    cmd_len   = len;
    check("cmd_ready_at_issue", 64'(cmd_ready), 64'(1));
    if (expect_it) begin
      for (int i = 0; i < nb; i++) exp_blk.push_back('{addr + 16'(4 * i), 8'(i)});
      exp_end.push_back('{cyc + 1 + lat, nb});
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_end(input string tn, input int exp_wm, output int rq);
    int  n = 0;
    int  wm = 0;
    bit  seen = 1'b0;
    rq = 0;
    while (!seen && n < 300) begin
      @(negedge clk);
      n++;
      if (mem_writeM) wm++;
      if (BUS_Request) rq++;
      if (dma_end) seen = 1'b1;
    end
    check({tn, "_end_seen"}, 64'(seen), 64'(1));
    check({tn, "_writeM_cycles"}, 64'(wm), 64'(exp_wm));
    @(negedge clk);
    check({tn, "_end_single_pulse"}, 64'(dma_end), 64'(0));
    check({tn, "_idle_ready"}, 64'(cmd_ready), 64'(1));
    check({tn, "_idle_not_busy"}, 64'(busy), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int  rq;
    bit  seen;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", 64'(cmd_ready), 64'(1));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_bus_req", 64'(BUS_Request), 64'(0));
    check("rst_writeM", 64'(mem_writeM), 64'(0));
    check("rst_mem_address", 64'(mem_address), 64'(0));
    check("rst_dev_block_idx", 64'(dev_block_idx), 64'(0));
    check("rst_dma_end", 64'(dma_end), 64'(0));
    reset = 1'b0;

    // 1: three blocks from 0x01F4, grant one cycle after request
    grant_delay = 0;
    issue(16'h01F4, 8'd12, 3, 13, 1'b1);
    wait_end("t1", 12, rq);
    $display("t1 addr=01f4 len=12 done");

    // 2: len 5 -> 2 blocks, grant delayed 10 cycles; command while busy ignored
    grant_delay = 10;
    issue(16'h0100, 8'd5, 2, 19, 1'b1);
    repeat (3) @(negedge clk);
    check("t2_req_held", 64'(BUS_Request), 64'(1));
    cmd_valid = 1'b1;
    cmd_addr  = 16'h2222;
    cmd_len   = 8'd4;
    check("t2_busy_not_ready", 64'(cmd_ready), 64'(0));
    check("t2_busy", 64'(busy), 64'(1));
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    wait_end("t2", 8, rq);
    grant_delay = 0;
    $display("t2 addr=0100 len=5 delayed grant done");

    // 3: grant dropped at cnt=2 of block 1 for 3 cycles -> block 1 retried
    drop_arm = 1'b1;
    issue(16'h0300, 8'd8, 2, 15, 1'b1);
    wait_end("t3", 11, rq);
    check("t3_drop_happened", 64'(drop_arm), 64'(0));
    $display("t3 addr=0300 len=8 grant drop done");

    // 4: zero-length command
    issue(16'h0400, 8'd0, 0, 0, 1'b1);
    wait_end("t4", 0, rq);
    check("t4_no_bus_req", 64'(rq), 64'(0));
    $display("t4 len=0 done");

    // 5: address wrap
    issue(16'hFFFC, 8'd8, 2, 9, 1'b1);
    wait_end("t5", 8, rq);
    $display("t5 addr=fffc len=8 wrap done");

    // 6: reset in the middle of WRITE, then a normal command
    issue(16'h0500, 8'd8, 2, 0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (mem_writeM) seen = 1'b1;
    end
    check("t6_reached_write", 64'(seen), 64'(1));
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("t6_rst_bus_req", 64'(BUS_Request), 64'(0));
    check("t6_rst_writeM", 64'(mem_writeM), 64'(0));
    check("t6_rst_cmd_ready", 64'(cmd_ready), 64'(1));
    check("t6_rst_busy", 64'(busy), 64'(0));
    issue(16'h0040, 8'd4, 1, 5, 1'b1);
    wait_end("t6", 4, rq);
    $display("t6 reset mid-write then addr=0040 len=4 done");

    repeat (3) @(negedge clk);
    check("blk_queue_drained", 64'(exp_blk.size()), 64'(0));
    check("end_queue_drained", 64'(exp_end.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
